// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encodings and byte-per-word helper for the imem loader
package imem_loader_pkg;

  // Loader frame states: header, payload, checksum, then a sticky outcome.
  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Bytes needed to carry one instruction word (ceil(w/8)).
  function automatic int calc_bpw(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles MSB-first stream bytes into instruction words
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          synchronous clear: drops a partial word and any pending word_valid
//   byte_valid   byte_data is consumed this cycle
//   byte_data    stream byte
//   word_fire    combinational: this byte completes a word
//   word_valid   one-cycle pulse, the cycle after word_fire
//   word         last completed word (bits above INSTR_W of the first byte dropped)
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               word_fire,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  localparam int BPW = calc_bpw(INSTR_W);
  localparam int SW  = BPW * 8;

  logic [SW-1:0] shreg;
  logic [SW-1:0] shnext;
  logic [2:0]    cnt;

  // Oldest bytes fall off the top; the truncation to INSTR_W below is what
  // discards the unused high bits of the first byte of each word.
  assign shnext    = SW'({shreg, byte_data});
  assign word_fire = byte_valid && (cnt == 3'(BPW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      shreg      <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_fire;
      if (byte_valid) begin
        if (word_fire) begin
          cnt   <= '0;
          shreg <= '0;
          word  <= INSTR_W'(shnext);
        end else begin
          cnt   <= cnt + 3'd1;
          shreg <= shnext;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory writer with CPU hold
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (frame ends with an XOR
// checksum byte over the payload; without it the frame ends after word N).
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          one-cycle pulse: abort any load and wait for a new header
//   s_data/s_valid/s_ready   byte stream, transfer when s_valid & s_ready
//   imem_we/imem_waddr/imem_wdata   synchronous imem write port
//   cpu_hold       high until a frame has been loaded and accepted
//   done, err      sticky frame outcome, cleared by start or rst
//   words_loaded   words written for the current frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam logic [8:0] MAX_N = 9'(1 << ADDR_W);

  state_t        state, state_nx;
  logic [ADDR_W:0] n_words;
  logic          accept;
  logic          all_rx;
  logic          hdr_bad;
  logic          word_fire;
  logic          last_fire;
  logic          pack_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  // words_loaded counts completed words at the edge each word completes, so
  // reaching n_words means every payload byte has already been taken.
  assign all_rx    = (words_loaded == n_words);
  assign last_fire = word_fire && (words_loaded == n_words - 1'b1);
  assign hdr_bad   = (s_data == 8'd0) || ({1'b0, s_data} > MAX_N);

  always_comb begin
    s_ready = 1'b0;
    if (!start) begin
      case (state)
        ST_HDR:   s_ready = 1'b1;
        ST_LOAD:  s_ready = !all_rx;
        ST_CHECK: s_ready = 1'b1;
        default:  s_ready = 1'b0;
      endcase
    end
  end

  assign accept     = s_valid && s_ready;
  assign pack_valid = accept && (state == ST_LOAD);

  byte_packer #(.INSTR_W(INSTR_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .byte_valid (pack_valid),
    .byte_data  (s_data),
    .word_fire  (word_fire),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HDR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_HDR: begin
        if (accept) state_nx = hdr_bad ? ST_ERR : ST_LOAD;
      end
      ST_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Leave as the last byte lands so a checksum byte right behind it is
        // taken at full rate; the final word is written during the first CHECK cycle.
        if (last_fire) state_nx = ST_CHECK;
`else
        if (imem_we && all_rx) state_nx = ST_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_nx = (s_data == chk) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_nx = state;
    endcase
    if (start) state_nx = ST_HDR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_words      <= '0;
      words_loaded <= '0;
      imem_waddr   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk          <= '0;
`endif
    end else if (start) begin
      words_loaded <= '0;
    end else begin
      if ((state == ST_HDR) && accept && !hdr_bad) begin
        n_words      <= (ADDR_W+1)'(s_data);
        words_loaded <= '0;
        imem_waddr   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk          <= '0;
`endif
      end
      if (word_fire) begin
        imem_waddr   <= words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (pack_valid) chk <= chk ^ s_data;
`endif
    end
  end

  assign cpu_hold = (state != ST_DONE);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (INSTR_W=12, ADDR_W=3)
module tb_imem_loader;

  localparam int IW = 12;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  imem_loader #(.INSTR_W(IW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int exp_addr[$];
  int exp_data[$];
  int frame_words[8];

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  // Scoreboard side: every write strobe must match the next expected word.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_addr.size() == 0) begin
        check("spurious_imem_we", 1, 0);
      end else begin
        check("imem_waddr", int'(imem_waddr), exp_addr.pop_front());
        check("imem_wdata", int'(imem_wdata), exp_data.pop_front());
      end
    end
  end

  // Offer one byte (with an optional random idle gap) and wait for acceptance.
  task automatic send_byte(input logic [7:0] b);
    int g;
    int t;
    g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    repeat (g) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    #1;
    t = 0;
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("accept_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Start pulse with a byte offered in the same cycle; that byte must be refused.
  task automatic rearm;
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    #1;
    check("start_cycle_ready", int'(s_ready), 0);
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("rearm_words_loaded", int'(words_loaded), 0);
    check("rearm_done", int'(done), 0);
    check("rearm_err", int'(err), 0);
    check("rearm_cpu_hold", int'(cpu_hold), 1);
    check("rearm_ready", int'(s_ready), 1);
    @(negedge clk);
  endtask

  task automatic wait_end(input bit exp_done, input int exp_words);
    int t;
    t = 0;
    while (!(done || err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (exp_addr.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("end_timeout", int'(t < 100), 1);
    @(negedge clk);
    check("done", int'(done), int'(exp_done));
    check("err", int'(err), int'(!exp_done));
    check("cpu_hold", int'(cpu_hold), int'(!exp_done));
    check("words_loaded", int'(words_loaded), exp_words);
    check("ready_after_frame", int'(s_ready), 0);
  endtask

  // Frame of n words from frame_words[]; the junk nibble above bit 11 must be dropped.
  task automatic send_frame(input int n, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] hi;
    logic [7:0] lo;
    bit ok_hdr;
    cs = 8'h00;
    ok_hdr = (n >= 1) && (n <= (1 << AW));
    send_byte(8'(n));
    if (!ok_hdr) begin
      wait_end(1'b0, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      hi = {4'($urandom_range(0, 15)), 4'(frame_words[i] >> 8)};
      lo = 8'(frame_words[i]);
      cs = cs ^ hi ^ lo;
      exp_addr.push_back(i);
      exp_data.push_back(frame_words[i] & 12'hFFF);
      send_byte(hi);
      send_byte(lo);
    end
    if (CHK_EN) send_byte(corrupt ? (cs ^ 8'h01) : cs);
    wait_end(!(CHK_EN && corrupt), n);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(s_ready), 1);
    check("rst_we", int'(imem_we), 0);
    check("rst_waddr", int'(imem_waddr), 0);
    check("rst_wdata", int'(imem_wdata), 0);
    check("rst_cpu_hold", int'(cpu_hold), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_words", int'(words_loaded), 0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word frame, good checksum.
    frame_words[0] = 12'h234;
    frame_words[1] = 12'hBCD;
    send_frame(2, 1'b0);

    // Bytes 01,F2,3A: the F nibble is outside the 12-bit word.
    rearm();
    exp_addr.push_back(0);
    exp_data.push_back(12'h23A);
    send_byte(8'h01);
    send_byte(8'hF2);
    send_byte(8'h3A);
    if (CHK_EN) send_byte(8'hF2 ^ 8'h3A);
    wait_end(1'b1, 1);

    // Same two words, bad checksum: words still land, frame rejected.
    rearm();
    send_frame(2, 1'b1);

    // Header boundaries: 0 and 9 rejected, 8 is the largest legal frame.
    rearm();
    send_frame(0, 1'b0);
    rearm();
    send_frame(9, 1'b0);
    rearm();
    for (int i = 0; i < 8; i++) frame_words[i] = $urandom_range(0, 4095);
    send_frame(8, 1'b0);

    // Abort after three payload bytes: word 0 completes, word 1 is dropped.
    rearm();
    send_byte(8'h04);
    exp_addr.push_back(0);
    exp_data.push_back(12'h567);
    send_byte(8'h05);
    send_byte(8'h67);
    send_byte(8'h89);
    repeat (3) @(negedge clk);
    rearm();
    check("queue_empty_after_start", exp_addr.size(), 0);
    frame_words[0] = 12'h9AB;
    frame_words[1] = 12'h0CD;
    frame_words[2] = 12'hE01;
    send_frame(3, 1'b0);

    // Randomized frames with random byte gaps.
    for (int f = 0; f < 15; f++) begin
      int n;
      rearm();
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) frame_words[i] = $urandom_range(0, 4095);
      send_frame(n, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset mid-LOAD, away from the clock edge.
    rearm();
    send_byte(8'h05);
    exp_addr.push_back(0);
    exp_data.push_back(12'h321);
    send_byte(8'h03);
    send_byte(8'h21);
    send_byte(8'h44);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", int'(s_ready), 1);
    check("midrst_we", int'(imem_we), 0);
    check("midrst_waddr", int'(imem_waddr), 0);
    check("midrst_wdata", int'(imem_wdata), 0);
    check("midrst_cpu_hold", int'(cpu_hold), 1);
    check("midrst_words", int'(words_loaded), 0);
    check("midrst_queue_empty", exp_addr.size(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame_words[0] = 12'h0F0;
    frame_words[1] = 12'h00F;
    send_frame(2, 1'b0);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_addr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
